prng_arbiter: RTL and testbench
===============================

# prng_arbiter

Round-robin controller sharing one 64-bit LCG-plus-permutation generator among `NREQ` requesters. It sequences the generator through its phases: arbitrate, advance the LCG state, apply the xorshift-6/rotate permutation, then present the result. Each grant yields one 64-bit draw. The block sits between the PRNG core datapath and consumer blocks, and replaces per-consumer generator instances.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `LCG_MUL`, 64'h5851F42D4C957F2D: LCG multiplier.
- `LCG_INC`, 64'h14057B7EF767814F: LCG increment (odd).
- `SEED`, 64'h853C49E6748FEA9B: state value loaded at reset.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `seed_valid` in 1: load `seed_in` as the LCG state.
- `seed_in` in 64: new state value.
- `seed_ack` out 1: one-cycle pulse when the seed is loaded.
- `req` in NREQ: per-requester request level.
- `gnt` out NREQ: one-hot, one-cycle pulse when a request is consumed.
- `rsp_valid` out 1: `rsp_data` and `rsp_id` valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out clog2(NREQ): index of the granted requester.
- `rsp_data` out 64: permuted draw.
- `draw_count` out 32: present only with `PRNG_ARB_STATS_EN`.

## Operation
- FSM states: IDLE, ADVANCE, PERMUTE, RESPOND.
- **IDLE, seed path:**
  - If `seed_valid`, then state ← `seed_in` and `seed_ack` pulses next cycle. FSM stays in IDLE.
  - The seed has priority over requests in the same cycle.
- **IDLE, request path:**
  - Else if `req` ≠ 0, pick the first set bit searching upward from (last granted + 1) mod NREQ, wrapping.
  - Latch the index into `rsp_id` and the pointer, then go to ADVANCE.
- **ADVANCE:**
  - state ← state·`LCG_MUL` + `LCG_INC`, truncated to 64 bits.
  - `gnt[rsp_id]` is high during this cycle only.
  - Go to PERMUTE.
- **PERMUTE:** with s = state:
  - x = s ^ (s >> 6); r = s[63:58].
  - `rsp_data` ← rotr(x, r).
  - r = 0 must yield x exactly. Do not form a 64-bit shift by 64.
  - Go to RESPOND.
- **RESPOND:**
  - `rsp_valid` = 1; `rsp_data` and `rsp_id` are held stable.
  - On `rsp_ready` = 1, go to IDLE.
- **Ignored inputs:**
  - `seed_valid` outside IDLE is ignored; no `seed_ack`. The source must hold it until acked.
  - `req` outside IDLE is not sampled. A requester keeps `req` high until it sees `gnt`. A requester still high after `gnt` is re-arbitrated as a new draw.

## Timing
- **Reset values:** FSM = IDLE, state = `SEED`, pointer = NREQ−1 (so requester 0 wins first). `gnt` = 0, `seed_ack` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `draw_count` = 0.
- **Grant and response latency:** if `req` is seen in IDLE at cycle T, then `gnt` is high at T+1, `rsp_valid` rises at T+3, and the earliest return to IDLE is T+4.
  - Peak throughput is one draw per 4 cycles.
  - Back-to-back `rsp_ready` adds no extra cycles.
- **Seed latency:** `seed_valid` seen in IDLE at T → `seed_ack` at T+1. The new state is used by a request arbitrated at T+1.
- **Reset mid-operation:** `rst` in any state returns to IDLE at the next edge. An in-flight draw is discarded and `rsp_valid` drops; no `gnt` is reissued.
- **Outputs:** all outputs are registered; no combinational path from input to output.

## Configuration
- **`PRNG_ARB_STATS_EN` defined:**
  - Adds the `draw_count` port.
  - It increments by 1 on each `rsp_valid && rsp_ready` cycle and wraps at 2^32.
  - It clears on `rst`, not on a seed load.
- **Not defined:** the port and the counter are absent; all other behaviour is identical.

## Structure
- **Shared package `prng_pkg`:**
  - FSM state enum (IDLE/ADVANCE/PERMUTE/RESPOND).
  - Default LCG_MUL/LCG_INC/SEED constants.
  - The 64-bit width constant.
- **Sub-module `prng_permute`:**
  - Purely combinational xorshift-6 plus rotate-right-by-top-6-bits function.
  - The arbiter instantiates it and registers its output in PERMUTE.
  - Keep the round-robin picker inline.

## Test plan
- **Single draw, zero-rotate case:**
  - Setup: `LCG_MUL`=1, `LCG_INC`=1; seed 0 (`seed_ack` at T+1); `req`=4'b0001.
  - Expected: `gnt`=0001 one cycle; `rsp_data`=64'h1, `rsp_id`=0 at T+3.
- **Max rotation:**
  - Setup: `LCG_MUL`=1, `LCG_INC`=1; seed 64'hFBFFFFFFFFFFFFFF.
  - Expected: s=64'hFC00000000000000, r=63; `rsp_data`=64'hFFE0000000000001.
- **Round-robin fairness:**
  - Setup: `req`=4'b1111 held, `rsp_ready`=1.
  - Expected: `gnt` sequence 0001, 0010, 0100, 1000, 0001, with `rsp_id` 0,1,2,3,0; one draw per 4 cycles.
  - Then `req`=4'b1010 starting after a grant to 1: next grants go to 3, then 1.
- **Backpressure:**
  - Setup: `rsp_ready`=0 for 5 cycles in RESPOND.
  - Expected: `rsp_data` and `rsp_id` stable; `seed_valid` raised meanwhile gets no ack until return to IDLE, then acks one cycle later.
- **Reset mid-draw:**
  - Setup: assert `rst` in PERMUTE.
  - Expected: next cycle `rsp_valid`=0, FSM in IDLE. The next draw with default params equals the draw from a fresh reset.
- **Stats (`PRNG_ARB_STATS_EN`):**
  - Setup: 6 completed handshakes with one interrupted by `rst`.
  - Expected: `draw_count` counts only handshakes since the last reset. Preload via force to 32'hFFFFFFFF; one handshake gives 0.

Source files
------------

// File: rtl/prng_pkg.sv
// prng_pkg: definitions shared by the PRNG arbiter slice.
//   - PRNG_W:        datapath width of the generator (64 bits)
//   - DEF_LCG_MUL:   default LCG multiplier
//   - DEF_LCG_INC:   default LCG increment (odd)
//   - DEF_SEED:      default state value loaded at reset
//   - fsm_state_t:   arbiter sequencing states
package prng_pkg;

  localparam int PRNG_W = 64;

  localparam logic [63:0] DEF_LCG_MUL = 64'h5851F42D4C957F2D;
  localparam logic [63:0] DEF_LCG_INC = 64'h14057B7EF767814F;
  localparam logic [63:0] DEF_SEED    = 64'h853C49E6748FEA9B;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADVANCE = 2'd1,
    ST_PERMUTE = 2'd2,
    ST_RESPOND = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/prng_permute.sv
// prng_permute: output permutation of the LCG state (purely combinational).
//   x = s ^ (s >> 6), r = s[63:58], y = rotr(x, r)
// Ports:
//   s  in  64  LCG state after the advance step
//   y  out 64  permuted draw
module prng_permute
  import prng_pkg::*;
(
  input  logic [PRNG_W-1:0] s,
  output logic [PRNG_W-1:0] y
);

  logic [PRNG_W-1:0] x;
  logic [5:0]        r;

  // Xorshift then rotate right. The rotate shifts a doubled copy of x so that
  // r = 0 returns x unchanged without ever shifting a 64-bit value by 64.
  always_comb begin
    x = s ^ (s >> 7'd6);
    r = s[63:58];
    y = PRNG_W'({x, x} >> r);
  end

endmodule

// File: rtl/prng_arbiter.sv
// prng_arbiter: round-robin sharing of one 64-bit LCG + permutation generator
// among NREQ requesters. Each grant yields one draw:
//   IDLE -> ADVANCE (gnt pulse, LCG step) -> PERMUTE (register draw)
//   -> RESPOND (hold until rsp_ready) -> IDLE
// Optional feature macro: PRNG_ARB_STATS_EN adds the draw_count port.
// Ports:
//   clk         in  1        rising-edge clock
//   rst         in  1        synchronous active-high reset
//   seed_valid  in  1        load seed_in as the LCG state (IDLE only)
//   seed_in     in  64       new LCG state
//   seed_ack    out 1        one-cycle pulse after the seed is loaded
//   req         in  NREQ     request levels
//   gnt         out NREQ     one-hot grant pulse (during ADVANCE)
//   rsp_valid   out 1        rsp_data / rsp_id valid
//   rsp_ready   in  1        consumer accepts the response
//   rsp_id      out clog2(NREQ) granted requester index
//   rsp_data    out 64       permuted draw
//   draw_count  out 32       completed handshakes (PRNG_ARB_STATS_EN only)
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int          NREQ    = 4,
  parameter logic [63:0] LCG_MUL = DEF_LCG_MUL,
  parameter logic [63:0] LCG_INC = DEF_LCG_INC,
  parameter logic [63:0] SEED    = DEF_SEED,
  localparam int         IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_valid,
  input  logic [PRNG_W-1:0] seed_in,
  output logic              seed_ack,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [PRNG_W-1:0] rsp_data
`ifdef PRNG_ARB_STATS_EN
  ,
  output logic [31:0]       draw_count
`endif
);

  fsm_state_t        fsm;
  logic [PRNG_W-1:0] lcg_state;
  logic [IDW-1:0]    ptr;
  logic [PRNG_W-1:0] perm_out;
  logic              pick_found;
  logic [IDW-1:0]    pick_idx;

  prng_permute u_permute (
    .s (lcg_state),
    .y (perm_out)
  );

  // Round-robin pick: first set request at or above ptr+1, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_found && req[(int'(ptr) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = IDW'((int'(ptr) + k) % NREQ);
      end else begin
        pick_found = pick_found;
      end
    end
  end

  // Sequencer: seed load, arbitration, LCG advance, permutation, response hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= ST_IDLE;
      lcg_state <= SEED;
      ptr       <= IDW'(NREQ - 1);
      gnt       <= '0;
      seed_ack  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      gnt      <= '0;
      seed_ack <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          // A pending seed wins over requests in the same cycle.
          if (seed_valid) begin
            lcg_state <= seed_in;
            seed_ack  <= 1'b1;
          end else if (pick_found) begin
            ptr    <= pick_idx;
            rsp_id <= pick_idx;
            gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
            fsm    <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          lcg_state <= lcg_state * LCG_MUL + LCG_INC;
          fsm       <= ST_PERMUTE;
        end
        ST_PERMUTE: begin
          rsp_data  <= perm_out;
          rsp_valid <= 1'b1;
          fsm       <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            fsm       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          fsm       <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PRNG_ARB_STATS_EN
  // Completed-handshake counter; wraps at 2^32, unaffected by seed loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      draw_count <= 32'd0;
    end else if (rsp_valid && rsp_ready) begin
      draw_count <= draw_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prng_arbiter.sv
// tb_prng_arbiter: directed self-checking bench for prng_arbiter.
// dut uses LCG_MUL=1, LCG_INC=1 so draws can be worked out by hand;
// dut2 uses the default parameters for the reset-mid-draw scenario.
module tb_prng_arbiter;

  localparam int          NREQ    = 4;
  localparam logic [63:0] MUL_DEF = 64'h5851F42D4C957F2D;
  localparam logic [63:0] INC_DEF = 64'h14057B7EF767814F;
  localparam logic [63:0] SEED_DEF = 64'h853C49E6748FEA9B;

  logic            clk = 1'b0;
  logic            rst;
  logic            seed_valid;
  logic [63:0]     seed_in;
  logic            seed_ack;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [63:0]     rsp_data;
  logic            seed_ack2;
  logic [NREQ-1:0] req2;
  logic [NREQ-1:0] gnt2;
  logic            rsp_valid2;
  logic [1:0]      rsp_id2;
  logic [63:0]     rsp_data2;
`ifdef PRNG_ARB_STATS_EN
  logic [31:0]     draw_count;
  logic [31:0]     draw_count2;
`endif

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] mstate;

  always #5 clk = ~clk;

  prng_arbiter #(.NREQ(NREQ), .LCG_MUL(64'd1), .LCG_INC(64'd1)) dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_in(seed_in),
    .seed_ack(seed_ack), .req(req), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef PRNG_ARB_STATS_EN
    , .draw_count(draw_count)
`endif
  );

  prng_arbiter #(.NREQ(NREQ)) dut2 (
    .clk(clk), .rst(rst), .seed_valid(1'b0), .seed_in(64'd0),
    .seed_ack(seed_ack2), .req(req2), .gnt(gnt2), .rsp_valid(rsp_valid2),
    .rsp_ready(1'b1), .rsp_id(rsp_id2), .rsp_data(rsp_data2)
`ifdef PRNG_ARB_STATS_EN
    , .draw_count(draw_count2)
`endif
  );

  // Reference permutation written bit by bit: out[i] = x[(i + r) mod 64].
  function automatic logic [63:0] model_perm(input logic [63:0] s);
    logic [63:0] x;
    logic [63:0] o;
    int          r;
    x = s ^ (s >> 6);
    r = int'(s[63:58]);
    for (int i = 0; i < 64; i++) o[i] = x[(i + r) % 64];
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_total++; if (gnt !== 4'b0000) $display("FAIL rst_gnt: got %b want 0000", gnt); else n_pass++;
    n_total++; if (seed_ack !== 1'b0) $display("FAIL rst_seed_ack: got %b want 0", seed_ack); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_id !== 2'd0) $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); else n_pass++;
    n_total++; if (rsp_data !== 64'd0) $display("FAIL rst_rsp_data: got %h want 0", rsp_data); else n_pass++;
`ifdef PRNG_ARB_STATS_EN
    n_total++; if (draw_count !== 32'd0) $display("FAIL rst_draw_count: got %0d want 0", draw_count); else n_pass++;
`endif
  endtask

  task automatic test_zero_rotate();
    seed_valid = 1'b1; seed_in = 64'd0;
    step();
    n_total++; if (seed_ack !== 1'b1) $display("FAIL zr_seed_ack: got %b want 1", seed_ack); else n_pass++;
    seed_valid = 1'b0; req = 4'b0001;
    step();
    n_total++; if (seed_ack !== 1'b0) $display("FAIL zr_seed_ack_pulse: got %b want 0", seed_ack); else n_pass++;
    n_total++; if (gnt !== 4'b0001) $display("FAIL zr_gnt: got %b want 0001", gnt); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL zr_valid_early: got %b want 0", rsp_valid); else n_pass++;
    req = 4'b0000;
    step();
    n_total++; if (gnt !== 4'b0000) $display("FAIL zr_gnt_once: got %b want 0000", gnt); else n_pass++;
    step();
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL zr_valid: got %b want 1", rsp_valid); else n_pass++;
    n_total++; if (rsp_data !== 64'h1) $display("FAIL zr_data: got %h want 1", rsp_data); else n_pass++;
    n_total++; if (rsp_id !== 2'd0) $display("FAIL zr_id: got %0d want 0", rsp_id); else n_pass++;
    rsp_ready = 1'b1;
    step();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL zr_valid_drop: got %b want 0", rsp_valid); else n_pass++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_max_rotate();
    seed_valid = 1'b1; seed_in = 64'hFBFFFFFFFFFFFFFF;
    step();
    n_total++; if (seed_ack !== 1'b1) $display("FAIL mr_seed_ack: got %b want 1", seed_ack); else n_pass++;
    seed_valid = 1'b0; req = 4'b0100;
    step();
    n_total++; if (gnt !== 4'b0100) $display("FAIL mr_gnt: got %b want 0100", gnt); else n_pass++;
    req = 4'b0000;
    step();
    step();
    n_total++; if (rsp_data !== 64'hFFE0000000000001) $display("FAIL mr_data: got %h want FFE0000000000001", rsp_data); else n_pass++;
    n_total++; if (rsp_id !== 2'd2) $display("FAIL mr_id: got %0d want 2", rsp_id); else n_pass++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_tail [2];
    exp_tail[0] = 3;
    exp_tail[1] = 1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mstate = SEED_DEF;
    req = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      n_total++; if (gnt !== (4'b0001 << (k % 4))) $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, 4'b0001 << (k % 4)); else n_pass++;
      if (k == 5) req = 4'b1010;
      mstate = mstate + 64'd1;
      step();
      step();
      n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4)) $display("FAIL rr_rsp[%0d]: got valid %b id %0d want valid 1 id %0d", k, rsp_valid, rsp_id, k % 4); else n_pass++;
      n_total++; if (rsp_data !== model_perm(mstate)) $display("FAIL rr_data[%0d]: got %h want %h", k, rsp_data, model_perm(mstate)); else n_pass++;
      step();
    end
    for (int j = 0; j < 2; j++) begin
      step();
      n_total++; if (gnt !== (4'b0001 << exp_tail[j])) $display("FAIL rr_tail_gnt[%0d]: got %b want %b", j, gnt, 4'b0001 << exp_tail[j]); else n_pass++;
      mstate = mstate + 64'd1;
      step();
      step();
      n_total++; if (rsp_id !== 2'(exp_tail[j])) $display("FAIL rr_tail_id[%0d]: got %0d want %0d", j, rsp_id, exp_tail[j]); else n_pass++;
      n_total++; if (rsp_data !== model_perm(mstate)) $display("FAIL rr_tail_data[%0d]: got %h want %h", j, rsp_data, model_perm(mstate)); else n_pass++;
      step();
    end
    req = 4'b0000; rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_data;
    req = 4'b0001;
    step();
    n_total++; if (gnt !== 4'b0001) $display("FAIL bp_gnt: got %b want 0001", gnt); else n_pass++;
    req = 4'b0000;
    mstate = mstate + 64'd1;
    exp_data = model_perm(mstate);
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        seed_valid = 1'b1; seed_in = 64'hFBFFFFFFFFFFFFFF;
      end
      step();
      n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== exp_data)
        $display("FAIL bp_hold[%0d]: got valid %b id %0d data %h want valid 1 id 0 data %h", c, rsp_valid, rsp_id, rsp_data, exp_data); else n_pass++;
      n_total++; if (seed_ack !== 1'b0) $display("FAIL bp_no_ack[%0d]: got %b want 0", c, seed_ack); else n_pass++;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_total++; if (rsp_valid !== 1'b0 || seed_ack !== 1'b0) $display("FAIL bp_return: got valid %b ack %b want 0 0", rsp_valid, seed_ack); else n_pass++;
    step();
    n_total++; if (seed_ack !== 1'b1) $display("FAIL bp_late_ack: got %b want 1", seed_ack); else n_pass++;
    seed_valid = 1'b0; req = 4'b1000;
    step();
    n_total++; if (gnt !== 4'b1000 || seed_ack !== 1'b0) $display("FAIL bp_next_gnt: got gnt %b ack %b want 1000 0", gnt, seed_ack); else n_pass++;
    req = 4'b0000;
    step();
    step();
    n_total++; if (rsp_data !== 64'hFFE0000000000001) $display("FAIL bp_seeded_data: got %h want FFE0000000000001", rsp_data); else n_pass++;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_draw();
    logic [63:0] exp2;
    exp2 = model_perm(SEED_DEF * MUL_DEF + INC_DEF);
    rst = 1'b1;
    step();
    rst = 1'b0;
    req2 = 4'b0001;
    step();
    n_total++; if (gnt2 !== 4'b0001) $display("FAIL rm_fresh_gnt: got %b want 0001", gnt2); else n_pass++;
    req2 = 4'b0000;
    step();
    step();
    n_total++; if (rsp_valid2 !== 1'b1 || rsp_data2 !== exp2) $display("FAIL rm_fresh_data: got valid %b data %h want 1 %h", rsp_valid2, rsp_data2, exp2); else n_pass++;
    step();
    req2 = 4'b0001;
    step();
    req2 = 4'b0000;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (rsp_valid2 !== 1'b0 || gnt2 !== 4'b0000 || rsp_valid !== 1'b0) $display("FAIL rm_after_rst: got valid2 %b gnt2 %b valid %b want 0 0000 0", rsp_valid2, gnt2, rsp_valid); else n_pass++;
    step();
    n_total++; if (gnt2 !== 4'b0000 || rsp_valid2 !== 1'b0 || seed_ack2 !== 1'b0) $display("FAIL rm_no_reissue: got gnt2 %b valid2 %b ack2 %b want 0000 0 0", gnt2, rsp_valid2, seed_ack2); else n_pass++;
    req2 = 4'b0001;
    step();
    n_total++; if (gnt2 !== 4'b0001) $display("FAIL rm_regnt: got %b want 0001", gnt2); else n_pass++;
    req2 = 4'b0000;
    step();
    step();
    n_total++; if (rsp_data2 !== exp2 || rsp_id2 !== 2'd0) $display("FAIL rm_redraw: got data %h id %0d want %h 0", rsp_data2, rsp_id2, exp2); else n_pass++;
    step();
  endtask

`ifdef PRNG_ARB_STATS_EN
  task automatic run_draw(input logic [NREQ-1:0] r);
    req = r; rsp_ready = 1'b1;
    step();
    req = 4'b0000;
    step();
    step();
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_stats();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (draw_count !== 32'd0) $display("FAIL st_clear: got %0d want 0", draw_count); else n_pass++;
    run_draw(4'b0001);
    run_draw(4'b0010);
    n_total++; if (draw_count !== 32'd2) $display("FAIL st_two: got %0d want 2", draw_count); else n_pass++;
    seed_valid = 1'b1; seed_in = 64'd5;
    step();
    seed_valid = 1'b0;
    n_total++; if (draw_count !== 32'd2) $display("FAIL st_seed_keep: got %0d want 2", draw_count); else n_pass++;
    req = 4'b0001;
    step();
    req = 4'b0000;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (draw_count !== 32'd0) $display("FAIL st_rst: got %0d want 0", draw_count); else n_pass++;
    for (int d = 0; d < 4; d++) run_draw(4'b1111);
    n_total++; if (draw_count !== 32'd4) $display("FAIL st_four: got %0d want 4", draw_count); else n_pass++;
    force dut.draw_count = 32'hFFFFFFFF;
    #1;
    release dut.draw_count;
    run_draw(4'b0001);
    n_total++; if (draw_count !== 32'd0) $display("FAIL st_wrap: got %0d want 0", draw_count); else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; seed_valid = 1'b0; seed_in = 64'd0;
    req = 4'b0000; req2 = 4'b0000; rsp_ready = 1'b0;
    step();
    step();
    test_reset();
    rst = 1'b0;
    test_zero_rotate();
    test_max_rotate();
    test_round_robin();
    test_backpressure();
    test_reset_mid_draw();
`ifdef PRNG_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
